spi_command_rx: RTL and testbench
=================================

# spi_command_rx

SPI slave front end that feeds the DSP engine's command port. It deserialises mode-0 SPI frames from the host MCU into command bytes, presenting each byte as a one-cycle `command_in`/`command_in_ready` write into the engine's command FIFO. On MISO it simultaneously returns a status byte so the host can throttle itself: sticky invalid-command flag, sticky overflow flag, and free FIFO space. It sits between the board SPI pins and the engine's command input, in the system clock domain.

## Interface
- `spi_fifo_length`, 32: depth of the engine command FIFO; sets the full threshold and free-space computation.
- `sync_stages`, 2: synchroniser flip-flops on `spi_sck`, `spi_cs_n` and `spi_mosi`; minimum 2.

- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `spi_sck`  in  1  SPI clock, asynchronous to `clk`, idle low (mode 0).
- `spi_cs_n`  in  1  chip select, active low, asynchronous.
- `spi_mosi`  in  1  host data, MSB first.
- `spi_miso`  out  1  status data, MSB first; driven 0 while deselected.
- `command_out`  out  8  received byte; connects to engine `command_in`.
- `command_out_ready`  out  1  one-cycle write strobe; connects to engine `command_in_ready`.
- `fifo_count`  in  $clog2(spi_fifo_length)+1  engine FIFO occupancy.
- `invalid_command`  in  1  engine invalid-command pulse/level.
- `rx_overflow`  out  1  sticky: a byte was dropped because the FIFO was full.

## Operation
- Synchronise `spi_sck`, `spi_cs_n`, `spi_mosi` through `sync_stages` FFs; keep one extra registered copy of sck and cs_n for edge detection.
- States: IDLE (cs_n high), SHIFT (cs_n low). IDLE->SHIFT on synchronised cs_n falling edge; SHIFT->IDLE on cs_n rising edge, from any bit position.
- On entering SHIFT and at every byte boundary: bit counter <- 0, load TX shift register with status snapshot and drive its bit 7 on `spi_miso`.
- Status byte: bit7 = invalid sticky, bit6 = overflow sticky, bits5:0 = `spi_fifo_length - fifo_count` saturated to 63.
- Invalid sticky sets when `invalid_command` is high; both stickies clear when a status byte is loaded at frame start (not at mid-frame byte boundaries). A set event in the same cycle as a clear wins (flag stays 1).
- sck rising edge (in SHIFT): shift `spi_mosi` into RX register LSB side, increment bit counter.
- sck falling edge (in SHIFT): shift TX register left; `spi_miso` <- new bit 7. Falling edge after the 8th rising edge triggers the reload above instead.
- 8th rising edge: if `fifo_count < spi_fifo_length`, `command_out` <- completed byte and pulse `command_out_ready`; otherwise drop byte, no strobe, set overflow sticky and `rx_overflow`.
- `rx_overflow` clears only on `reset` (the status-bit copy clears per frame).
- cs_n rising mid-byte: discard partial bits, no strobe, `spi_miso` <- 0.
- sck edges while in IDLE ignored.

## Timing
- Reset values: `spi_miso` 0, `command_out` 0x00, `command_out_ready` 0, `rx_overflow` 0, stickies 0, state IDLE, counters 0.
- `clk` must be at least 8x `spi_sck`; sck high and low phases must each last at least 3 `clk` cycles.
- Input-to-detect latency: `sync_stages`+1 cycles from a pin edge to internal edge pulse.
- `command_out_ready` is high for exactly one cycle, registered, the cycle after the 8th rising edge is detected; `command_out` is stable from that cycle until the next strobe.
- `spi_miso` updates one cycle after the detected falling edge or cs_n falling edge; valid well before the next sck rising edge given the ratio above.
- Back-to-back bytes in one frame produce strobes at least 8 sck periods apart; no internal buffering beyond one byte.
- `reset` mid-frame: everything returns to reset values; remaining bits of that frame are ignored until cs_n goes high and low again.

## Test plan
- `fifo_count`=0, one frame sending 0xA5 -> exactly one `command_out_ready` pulse, `command_out`=0xA5, `rx_overflow` 0.
- `spi_fifo_length`=32, `fifo_count`=5, frame of one byte -> MISO returns 0x1B; three-byte frame 0x01 0x02 0x03 -> three strobes in order.
- Pulse `invalid_command` once, then two frames -> first status 0x80|free, second status bit7 = 0; invalid pulse coinciding with frame-start load -> bit7 still set next frame.
- `fifo_count`=32, send 0x11 -> no strobe, `rx_overflow`=1; next frame status = 0x40; following frame status bit6 = 0, `rx_overflow` still 1.
- Raise cs_n after 5 bits, then send 0x3C -> no strobe for partial byte, one strobe with 0x3C.
- Assert `reset` after 4 bits of 0xFF, restart frame with 0x5A -> only 0x5A strobed, all outputs at reset values during reset.

Source files
------------

// File: rtl/spi_command_rx_if.sv
// spi_command_rx_if: SPI pins plus engine command-port signals of spi_command_rx.
interface spi_command_rx_if #(
  parameter int spi_fifo_length = 32
);
  logic spi_sck;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;
  logic [7:0] command_out;
  logic command_out_ready;
  logic [$clog2(spi_fifo_length):0] fifo_count;
  logic invalid_command;
  logic rx_overflow;
  modport master (
    output spi_sck, spi_cs_n, spi_mosi, fifo_count, invalid_command,
    input  spi_miso, command_out, command_out_ready, rx_overflow
  );
  modport slave (
    input  spi_sck, spi_cs_n, spi_mosi, fifo_count, invalid_command,
    output spi_miso, command_out, command_out_ready, rx_overflow
  );
endinterface

// File: rtl/spi_command_rx.sv
// spi_command_rx: mode-0 SPI slave turning host bytes into engine command writes, returning status on MISO.
module spi_command_rx #(
  parameter int spi_fifo_length = 32,
  parameter int sync_stages = 2
) (
  input logic clk,
  input logic reset,
  spi_command_rx_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [sync_stages-1:0] sck_sync, cs_sync, mosi_sync;
  logic sck_d, cs_d;
  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic frame_start, active, byte_done, byte_load, fifo_ok;
  logic [3:0] bit_cnt;
  logic [6:0] rx_sr;
  logic [7:0] tx_sr;
  logic inv_st, ovf_st;
  logic [31:0] free_w;
  logic [7:0] status;
  // Synchronisers are left unreset so a reset with cs_n already low cannot fake a frame start.
  always_ff @(posedge clk) begin
    sck_sync <= {sck_sync[sync_stages-2:0], bus.spi_sck};
    cs_sync <= {cs_sync[sync_stages-2:0], bus.spi_cs_n};
    mosi_sync <= {mosi_sync[sync_stages-2:0], bus.spi_mosi};
    sck_d <= sck_s;
    cs_d <= cs_s;
  end
  assign sck_s = sck_sync[sync_stages-1];
  assign cs_s = cs_sync[sync_stages-1];
  assign mosi_s = mosi_sync[sync_stages-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_rise = cs_s & ~cs_d;
  assign cs_fall = ~cs_s & cs_d;
  assign fifo_ok = 32'(bus.fifo_count) < 32'(spi_fifo_length);
  assign free_w = fifo_ok ? 32'(spi_fifo_length) - 32'(bus.fifo_count) : 32'd0;
  assign status = {inv_st, ovf_st, free_w > 32'd63 ? 6'd63 : free_w[5:0]};
  assign bus.spi_miso = tx_sr[7];
  always_comb begin
    state_nx = (state == IDLE && cs_fall) ? SHIFT : (state == SHIFT && cs_rise) ? IDLE : state;
    frame_start = state == IDLE && cs_fall;
    active = state == SHIFT && !cs_rise;
    byte_done = active && sck_rise && bit_cnt == 4'd7;
    byte_load = active && sck_fall && bit_cnt == 4'd8;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bit_cnt <= '0;
      rx_sr <= '0;
      tx_sr <= '0;
      inv_st <= 1'b0;
      ovf_st <= 1'b0;
      bus.command_out <= '0;
      bus.command_out_ready <= 1'b0;
      bus.rx_overflow <= 1'b0;
    end else begin
      state <= state_nx;
      bus.command_out_ready <= byte_done && fifo_ok;
      inv_st <= bus.invalid_command | (inv_st & ~frame_start);
      ovf_st <= (byte_done & ~fifo_ok) | (ovf_st & ~frame_start);
      if (byte_done && !fifo_ok) bus.rx_overflow <= 1'b1;
      if (byte_done && fifo_ok) bus.command_out <= {rx_sr, mosi_s};
      if (active && sck_rise) begin
        rx_sr <= {rx_sr[5:0], mosi_s};
        bit_cnt <= bit_cnt + 4'd1;
      end
      // Frame start and byte boundaries reload the status; only frame start clears the stickies.
      if (frame_start || byte_load) begin
        bit_cnt <= '0;
        tx_sr <= status;
      end else if (active && sck_fall) begin
        tx_sr <= {tx_sr[6:0], 1'b0};
      end else if (state == SHIFT && cs_rise) begin
        tx_sr <= '0;
      end
    end
  end
endmodule

// File: tb/tb_spi_command_rx.sv
// tb_spi_command_rx: directed and random SPI frames checked against a frame-level model.
module tb_spi_command_rx;
  localparam int LEN = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  spi_command_rx_if #(.spi_fifo_length(LEN)) ifc ();
  spi_command_rx #(.spi_fifo_length(LEN), .sync_stages(2)) dut (.clk(clk), .reset(reset), .bus(ifc.slave));
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  bit m_inv, m_ovf, m_rxovf;
  logic [7:0] pend;

  always @(negedge clk) if (ifc.command_out_ready) got.push_back(ifc.command_out);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] stat();
    int f;
    f = LEN - int'(ifc.fifo_count);
    if (f < 0) f = 0;
    if (f > 63) f = 63;
    return {m_inv, m_ovf, f[5:0]};
  endfunction

  task automatic pulse_invalid();
    ifc.invalid_command = 1'b1;
    wait_clk(1);
    ifc.invalid_command = 1'b0;
    m_inv = 1'b1;
    wait_clk(2);
  endtask

  task automatic cs_low();
    ifc.spi_cs_n = 1'b0;
    pend = stat();
    m_inv = 1'b0;
    m_ovf = 1'b0;
    wait_clk(6);
  endtask

  task automatic cs_high(input string tag);
    ifc.spi_cs_n = 1'b1;
    wait_clk(6);
    chk({tag, "_miso_idle"}, 32'(ifc.spi_miso), 32'd0);
  endtask

  task automatic bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      ifc.spi_mosi = b[7-i];
      wait_clk(6);
      ifc.spi_sck = 1'b1;
      wait_clk(6);
      ifc.spi_sck = 1'b0;
    end
    wait_clk(6);
  endtask

  task automatic xfer(input logic [7:0] b, input int fcc, input string tag);
    logic [7:0] st;
    logic [7:0] seen;
    st = pend;
    seen = '0;
    for (int i = 0; i < 8; i++) begin
      ifc.spi_mosi = b[7-i];
      wait_clk(6);
      seen[7-i] = ifc.spi_miso;
      ifc.spi_sck = 1'b1;
      wait_clk(6);
      if (i == 3) ifc.fifo_count = 6'(fcc);
      ifc.spi_sck = 1'b0;
    end
    wait_clk(6);
    if (fcc < LEN) exp_q.push_back(b);
    else begin
      m_ovf = 1'b1;
      m_rxovf = 1'b1;
    end
    pend = stat();
    chk({tag, "_status"}, 32'(seen), 32'(st));
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    while (got.size() > 0 && exp_q.size() > 0) chk({tag, "_byte"}, 32'(got.pop_front()), 32'(exp_q.pop_front()));
    got.delete();
    exp_q.delete();
    chk({tag, "_rx_overflow"}, 32'(ifc.rx_overflow), 32'(m_rxovf));
  endtask

  task automatic frame(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input int fcc, input string tag);
    logic [7:0] bs[3];
    bs[0] = b0;
    bs[1] = b1;
    bs[2] = b2;
    cs_low();
    for (int k = 0; k < n; k++) xfer(bs[k], fcc, tag);
    cs_high(tag);
    check_out(tag);
  endtask

  initial begin
    ifc.spi_sck = 1'b0;
    ifc.spi_cs_n = 1'b1;
    ifc.spi_mosi = 1'b0;
    ifc.fifo_count = '0;
    ifc.invalid_command = 1'b0;
    wait_clk(4);
    chk("rst_miso", 32'(ifc.spi_miso), 32'd0);
    chk("rst_cmd", 32'(ifc.command_out), 32'd0);
    chk("rst_ready", 32'(ifc.command_out_ready), 32'd0);
    chk("rst_ovf", 32'(ifc.rx_overflow), 32'd0);
    reset = 1'b0;
    wait_clk(4);

    frame(1, 8'hA5, 8'h00, 8'h00, 0, "a5");
    ifc.fifo_count = 6'd5;
    frame(1, 8'h77, 8'h00, 8'h00, 5, "free27");
    frame(3, 8'h01, 8'h02, 8'h03, 5, "three");

    pulse_invalid();
    frame(1, 8'h42, 8'h00, 8'h00, 5, "inv1");
    frame(1, 8'h43, 8'h00, 8'h00, 5, "inv2");

    ifc.spi_cs_n = 1'b0;
    pend = stat();
    m_inv = 1'b0;
    m_ovf = 1'b0;
    wait_clk(2);
    ifc.invalid_command = 1'b1;
    wait_clk(1);
    ifc.invalid_command = 1'b0;
    m_inv = 1'b1;
    wait_clk(3);
    xfer(8'h44, 5, "coin1");
    cs_high("coin1");
    check_out("coin1");
    frame(1, 8'h45, 8'h00, 8'h00, 5, "coin2");

    ifc.fifo_count = 6'd32;
    frame(1, 8'h11, 8'h00, 8'h00, 32, "full");
    frame(1, 8'h12, 8'h00, 8'h00, 0, "ovf_status");
    frame(1, 8'h13, 8'h00, 8'h00, 0, "ovf_clear");

    cs_low();
    bits(8'hFF, 5);
    cs_high("partial");
    frame(1, 8'h3C, 8'h00, 8'h00, 0, "after_partial");

    for (int r = 0; r < 20; r++) begin
      int n, fc, fcc;
      n = int'($urandom_range(1, 3));
      fc = ($urandom_range(0, 3) == 0) ? LEN : int'($urandom_range(0, LEN));
      fcc = ($urandom_range(0, 3) == 0) ? LEN : int'($urandom_range(0, LEN));
      ifc.fifo_count = 6'(fc);
      if ($urandom_range(0, 2) == 0) pulse_invalid();
      frame(n, 8'($urandom), 8'($urandom), 8'($urandom), fcc, "rand");
    end

    ifc.fifo_count = 6'd0;
    cs_low();
    bits(8'hFF, 4);
    reset = 1'b1;
    wait_clk(3);
    chk("mid_rst_miso", 32'(ifc.spi_miso), 32'd0);
    chk("mid_rst_cmd", 32'(ifc.command_out), 32'd0);
    chk("mid_rst_ready", 32'(ifc.command_out_ready), 32'd0);
    chk("mid_rst_ovf", 32'(ifc.rx_overflow), 32'd0);
    m_inv = 1'b0;
    m_ovf = 1'b0;
    m_rxovf = 1'b0;
    reset = 1'b0;
    wait_clk(2);
    bits(8'hF0, 4);
    cs_high("post_rst");
    got.delete();
    got.push_back(8'h00);
    got.pop_front();
    frame(1, 8'h5A, 8'h00, 8'h00, 0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
